wb_ic_1x4: RTL and testbench

Single-master, four-slave Wishbone classic interconnect with a timeout guard. It sits directly downstream of the CPU's Wishbone master bridge and routes each CPU access to one of four slave windows (boot RAM, data RAM, CSR block, Ethernet/crypto CSRs). The CPU bridge has no bus-error input. Unmapped accesses and slaves that never respond are therefore terminated here with an ack carrying ERR_DATA, so the core never hangs. Error events are counted for firmware and debug.

---
 rtl/wb_ic_1x4_if.sv | 39 +++
 rtl/wb_ic_1x4.sv | 147 ++++++++++++++
 tb/tb_wb_ic_1x4.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_ic_1x4_if.sv
// Signal bundle for wb_ic_1x4: CPU-bridge port, shared downstream bus and error status.
interface wb_ic_1x4_if;
   logic [31:0]  wbs_adr_i;
   logic [31:0]  wbs_dat_i;
   logic         wbs_we_i;
   logic [3:0]   wbs_sel_i;
   logic         wbs_stb_i;
   logic         wbs_cyc_i;
   logic [31:0]  wbs_dat_o;
   logic         wbs_ack_o;
   logic [31:0]  wbm_adr_o;
   logic [31:0]  wbm_dat_o;
   logic         wbm_we_o;
   logic [3:0]   wbm_sel_o;
   logic [3:0]   wbm_stb_o;
   logic [3:0]   wbm_cyc_o;
   logic [127:0] wbm_dat_i;
   logic [3:0]   wbm_ack_i;
   logic         err_o;
   logic [31:0]  err_adr_o;
   logic [15:0]  err_cnt_o;

   // slave: the interconnect itself; master: the CPU bridge and slave windows around it
   modport slave (
      input  wbs_adr_i, wbs_dat_i, wbs_we_i, wbs_sel_i, wbs_stb_i, wbs_cyc_i,
      input  wbm_dat_i, wbm_ack_i,
      output wbs_dat_o, wbs_ack_o,
      output wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_stb_o, wbm_cyc_o,
      output err_o, err_adr_o, err_cnt_o
   );

   modport master (
      output wbs_adr_i, wbs_dat_i, wbs_we_i, wbs_sel_i, wbs_stb_i, wbs_cyc_i,
      output wbm_dat_i, wbm_ack_i,
      input  wbs_dat_o, wbs_ack_o,
      input  wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_stb_o, wbm_cyc_o,
      input  err_o, err_adr_o, err_cnt_o
   );
endinterface

// File: rtl/wb_ic_1x4.sv
// Single-master, four-slave Wishbone classic interconnect. Unmapped accesses and
// silent slaves are terminated locally with an ERR_DATA ack and counted.
//
// state | meaning
// IDLE  | waiting for cyc & stb from the CPU bridge
// FWD   | request latched; strobing the decoded slave (or flagging a decode miss)
// RESP  | one-cycle ack upstream, wbs_dat_o already valid
module wb_ic_1x4 #(
   parameter logic [31:0] S0_BASE      = 32'h0000_0000,
   parameter logic [31:0] S1_BASE      = 32'h1000_0000,
   parameter logic [31:0] S2_BASE      = 32'h2000_0000,
   parameter logic [31:0] S3_BASE      = 32'h3000_0000,
   parameter logic [31:0] S_MASK       = 32'hF000_0000,
   parameter int unsigned TIMEOUT_CYC  = 255,
   parameter logic [31:0] ERR_DATA     = 32'hDEAD_BEEF,
   parameter logic [15:0] ERR_CNT_INIT = 16'h0000
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_i,
   wb_ic_1x4_if.slave bus
);

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FWD  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state_q, state_n;
   logic [31:0] adr_q, dat_q, rdat_q, err_adr_q;
   logic        we_q;
   logic [3:0]  sel_q;
   logic        err_q;
   logic [15:0] err_cnt_q;
   logic [15:0] tmo_q;

   logic [3:0]  hit;
   logic [31:0] hit_dat;
   logic        hit_ack;
   logic        req_take, ack_take, err_evt, tmo_inc;

   // Decode runs on the latched address; lowest index wins on overlap.
   always_comb begin
      hit = 4'b0000;
      if ((adr_q & S_MASK) == (S0_BASE & S_MASK))      hit = 4'b0001;
      else if ((adr_q & S_MASK) == (S1_BASE & S_MASK)) hit = 4'b0010;
      else if ((adr_q & S_MASK) == (S2_BASE & S_MASK)) hit = 4'b0100;
      else if ((adr_q & S_MASK) == (S3_BASE & S_MASK)) hit = 4'b1000;
   end

   always_comb begin
      hit_dat = 32'h0;
      for (int i = 0; i < 4; i++) begin
         if (hit[i]) hit_dat = bus.wbm_dat_i[32*i +: 32];
      end
   end

   assign hit_ack = |(hit & bus.wbm_ack_i);

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) state_q <= IDLE;
      else          state_q <= state_n;
   end

   always_comb begin
      state_n  = state_q;
      req_take = 1'b0;
      ack_take = 1'b0;
      err_evt  = 1'b0;
      tmo_inc  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.wbs_cyc_i && bus.wbs_stb_i) begin
               req_take = 1'b1;
               state_n  = FWD;
            end
         end
         FWD: begin
            if (!bus.wbs_cyc_i) begin
               state_n = IDLE;
            end else if (hit == 4'b0000) begin
               err_evt = 1'b1;
               state_n = RESP;
            end else if (hit_ack) begin
               // an ack on the terminal cycle still wins over the timeout
               ack_take = 1'b1;
               state_n  = RESP;
            end else if (tmo_q == TMO_LAST) begin
               err_evt = 1'b1;
               state_n = RESP;
            end else begin
               tmo_inc = 1'b1;
            end
         end
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         adr_q     <= 32'h0;
         dat_q     <= 32'h0;
         we_q      <= 1'b0;
         sel_q     <= 4'h0;
         rdat_q    <= 32'h0;
         tmo_q     <= 16'h0;
         err_q     <= 1'b0;
         err_adr_q <= 32'h0;
         err_cnt_q <= ERR_CNT_INIT;
      end else begin
         err_q <= err_evt;
         if (req_take) begin
            adr_q <= bus.wbs_adr_i;
            dat_q <= bus.wbs_dat_i;
            we_q  <= bus.wbs_we_i;
            sel_q <= bus.wbs_sel_i;
            tmo_q <= 16'h0;
         end
         if (tmo_inc) tmo_q <= tmo_q + 16'd1;
         if (ack_take) begin
            rdat_q <= hit_dat;
            we_q   <= 1'b0;
         end
         if (err_evt) begin
            rdat_q    <= ERR_DATA;
            err_adr_q <= adr_q;
            if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
         end
      end
   end

   assign bus.wbs_dat_o = rdat_q;
   assign bus.wbs_ack_o = (state_q == RESP);
   assign bus.wbm_adr_o = adr_q;
   assign bus.wbm_dat_o = dat_q;
   assign bus.wbm_we_o  = we_q;
   assign bus.wbm_sel_o = sel_q;
   assign bus.wbm_stb_o = (state_q == FWD) ? hit : 4'b0000;
   assign bus.wbm_cyc_o = (state_q == FWD) ? hit : 4'b0000;
   assign bus.err_o     = err_q;
   assign bus.err_adr_o = err_adr_q;
   assign bus.err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_wb_ic_1x4.sv
// Scoreboard bench for wb_ic_1x4: directed cases plus random traffic against a window-level model.
module tb_wb_ic_1x4;
   localparam int          TMO       = 8;
   localparam logic [31:0] ERR_DATA  = 32'hDEAD_BEEF;
   localparam logic [15:0] CNT2_INIT = 16'hFFFD;

   logic wb_clk_i = 1'b0;
   logic wb_rst_i = 1'b1;

   wb_ic_1x4_if bus ();
   wb_ic_1x4_if bus2 ();

   wb_ic_1x4 #(.TIMEOUT_CYC(TMO)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .bus(bus));

   // Second copy sees identical traffic but starts its error counter near saturation.
   wb_ic_1x4 #(.TIMEOUT_CYC(TMO), .ERR_CNT_INIT(CNT2_INIT)) dut_sat (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .bus(bus2));

   assign bus2.wbs_adr_i = bus.wbs_adr_i;
   assign bus2.wbs_dat_i = bus.wbs_dat_i;
   assign bus2.wbs_we_i  = bus.wbs_we_i;
   assign bus2.wbs_sel_i = bus.wbs_sel_i;
   assign bus2.wbs_stb_i = bus.wbs_stb_i;
   assign bus2.wbs_cyc_i = bus.wbs_cyc_i;
   assign bus2.wbm_dat_i = bus.wbm_dat_i;
   assign bus2.wbm_ack_i = bus.wbm_ack_i;

   always #5 wb_clk_i = ~wb_clk_i;

   typedef struct {
      logic [31:0] dat;
      bit          err;
      logic [31:0] adr;
      logic [15:0] cnt;
      logic [15:0] cnt2;
      int          edge_n;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   int checks = 0;
   int failures = 0;
   int edge_cnt = 0;

   logic [3:0]  exp_oh = 4'h0;
   logic [31:0] exp_adr = 32'h0, exp_wdat = 32'h0, s_rdata = 32'h0;
   logic        exp_we = 1'b0;
   logic [3:0]  exp_sel = 4'h0;
   int          s_wait = 0;
   bit          s_never = 1'b0;
   bit          stray_en = 1'b0;
   int          s_cnt = 0;
   logic [15:0] m_cnt = 16'h0;
   logic [15:0] m_cnt2 = CNT2_INIT;

   always @(posedge wb_clk_i) edge_cnt <= edge_cnt + 1;

   task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Slave windows: the selected slave acks after s_wait strobe cycles; others may ack stray.
   always begin
      @(posedge wb_clk_i);
      #1;
      if (!wb_rst_i && bus.wbm_stb_o != 4'h0) begin
         chk(bus.wbm_stb_o == exp_oh, "stb_onehot", 32'(bus.wbm_stb_o), 32'(exp_oh));
         chk(bus.wbm_cyc_o == exp_oh, "cyc_onehot", 32'(bus.wbm_cyc_o), 32'(exp_oh));
         if (s_cnt == 0) begin
            chk(bus.wbm_adr_o == exp_adr, "down_adr", bus.wbm_adr_o, exp_adr);
            chk(bus.wbm_dat_o == exp_wdat, "down_dat", bus.wbm_dat_o, exp_wdat);
            chk(bus.wbm_we_o == exp_we, "down_we", 32'(bus.wbm_we_o), 32'(exp_we));
            chk(bus.wbm_sel_o == exp_sel, "down_sel", 32'(bus.wbm_sel_o), 32'(exp_sel));
         end
      end
      for (int i = 0; i < 4; i++) begin
         if (bus.wbm_stb_o[i] === 1'b1) begin
            bus.wbm_dat_i[32*i +: 32] = s_rdata;
            bus.wbm_ack_i[i] = !s_never && (s_cnt == s_wait);
         end else begin
            bus.wbm_dat_i[32*i +: 32] = $urandom;
            bus.wbm_ack_i[i] = stray_en && ($urandom_range(0, 1) == 1);
         end
      end
      s_cnt = (bus.wbm_stb_o != 4'h0) ? s_cnt + 1 : 0;
   end

   // Upstream monitor: every ack pops one expected response.
   always @(negedge wb_clk_i) begin
      if (!wb_rst_i) begin
         if (bus.wbs_ack_o) begin
            chk(exp_q.size() != 0, "ack_expected", bus.wbs_dat_o, 32'(exp_q.size()));
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               chk(bus.wbs_dat_o == mon_e.dat, "rdata", bus.wbs_dat_o, mon_e.dat);
               chk(bus.err_o == mon_e.err, "err_pulse", 32'(bus.err_o), 32'(mon_e.err));
               chk(bus.err_cnt_o == mon_e.cnt, "err_cnt", 32'(bus.err_cnt_o), 32'(mon_e.cnt));
               chk(bus2.err_cnt_o == mon_e.cnt2, "err_cnt_sat", 32'(bus2.err_cnt_o), 32'(mon_e.cnt2));
               chk(edge_cnt == mon_e.edge_n, "ack_latency", 32'(edge_cnt), 32'(mon_e.edge_n));
               if (mon_e.err)
                  chk(bus.err_adr_o == mon_e.adr, "err_adr", bus.err_adr_o, mon_e.adr);
            end
         end else begin
            chk(bus.err_o == 1'b0, "err_without_ack", 32'(bus.err_o), 32'h0);
         end
      end
   end

   task automatic check_all_zero(input string tag);
      chk(bus.wbs_ack_o == 1'b0, {tag, "_ack"}, 32'(bus.wbs_ack_o), 32'h0);
      chk(bus.wbs_dat_o == 32'h0, {tag, "_rdat"}, bus.wbs_dat_o, 32'h0);
      chk(bus.wbm_stb_o == 4'h0, {tag, "_stb"}, 32'(bus.wbm_stb_o), 32'h0);
      chk(bus.wbm_cyc_o == 4'h0, {tag, "_cyc"}, 32'(bus.wbm_cyc_o), 32'h0);
      chk(bus.wbm_adr_o == 32'h0, {tag, "_adr"}, bus.wbm_adr_o, 32'h0);
      chk(bus.wbm_dat_o == 32'h0, {tag, "_wdat"}, bus.wbm_dat_o, 32'h0);
      chk(bus.wbm_we_o == 1'b0, {tag, "_we"}, 32'(bus.wbm_we_o), 32'h0);
      chk(bus.wbm_sel_o == 4'h0, {tag, "_sel"}, 32'(bus.wbm_sel_o), 32'h0);
      chk(bus.err_o == 1'b0, {tag, "_err"}, 32'(bus.err_o), 32'h0);
      chk(bus.err_adr_o == 32'h0, {tag, "_err_adr"}, bus.err_adr_o, 32'h0);
      chk(bus.err_cnt_o == 16'h0, {tag, "_err_cnt"}, 32'(bus.err_cnt_o), 32'h0);
      chk(bus2.err_cnt_o == CNT2_INIT, {tag, "_err_cnt_sat"}, 32'(bus2.err_cnt_o), 32'(CNT2_INIT));
   endtask

   task automatic drive_req(input logic [31:0] adr, input bit we, input logic [31:0] wdat,
                            input logic [3:0] sel, input int w, input bit never,
                            input logic [31:0] rdata, output int n_edge);
      logic [3:0] win;
      @(posedge wb_clk_i);
      #1;
      win      = adr[31:28];
      exp_oh   = (win < 4'd4) ? (4'b0001 << win) : 4'b0000;
      exp_adr  = adr;
      exp_wdat = wdat;
      exp_we   = we;
      exp_sel  = sel;
      s_wait   = w;
      s_never  = never;
      s_rdata  = rdata;
      bus.wbs_adr_i = adr;
      bus.wbs_dat_i = wdat;
      bus.wbs_we_i  = we;
      bus.wbs_sel_i = sel;
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      n_edge = edge_cnt + 1;
   endtask

   task automatic do_txn(input logic [31:0] adr, input bit we, input logic [31:0] wdat,
                         input logic [3:0] sel, input int w, input bit never,
                         input logic [31:0] rdata);
      exp_t e;
      int   n;
      bit   hit;
      bit   got;
      drive_req(adr, we, wdat, sel, w, never, rdata, n);
      hit = (adr[31:28] < 4'd4);
      e.adr = adr;
      if (hit && !never && w < TMO) begin
         e.dat = rdata;
         e.err = 1'b0;
         e.edge_n = n + 1 + w;
      end else begin
         e.dat = ERR_DATA;
         e.err = 1'b1;
         e.edge_n = hit ? n + TMO : n + 1;
         if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
         if (m_cnt2 != 16'hFFFF) m_cnt2 = m_cnt2 + 16'd1;
      end
      e.cnt  = m_cnt;
      e.cnt2 = m_cnt2;
      exp_q.push_back(e);
      got = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(posedge wb_clk_i);
         #1;
         if (bus.wbs_ack_o) begin
            got = 1'b1;
            break;
         end
      end
      chk(got, "ack_within_budget", adr, 32'(got));
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
   endtask

   initial begin
      int n;
      bus.wbs_adr_i = 32'h0;
      bus.wbs_dat_i = 32'h0;
      bus.wbs_we_i  = 1'b0;
      bus.wbs_sel_i = 4'h0;
      bus.wbs_stb_i = 1'b0;
      bus.wbs_cyc_i = 1'b0;
      bus.wbm_ack_i = 4'h0;
      bus.wbm_dat_i = '0;
      wb_rst_i = 1'b1;
      repeat (3) @(posedge wb_clk_i);
      #1;
      check_all_zero("reset");
      wb_rst_i = 1'b0;

      do_txn(32'h1000_0040, 1'b0, 32'h0, 4'hF, 3, 1'b0, 32'h1234_5678);
      do_txn(32'h2000_0004, 1'b1, 32'hA5A5_A5A5, 4'b0011, 1, 1'b0, 32'h0BAD_F00D);
      do_txn(32'h7000_0000, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'h5555_AAAA);
      do_txn(32'h3000_0008, 1'b0, 32'h0, 4'hF, 0, 1'b1, 32'h0);
      do_txn(32'h3000_000C, 1'b0, 32'h0, 4'hF, TMO - 1, 1'b0, 32'hCAFE_0001);
      do_txn(32'h3000_0010, 1'b0, 32'h0, 4'hF, TMO, 1'b0, 32'hCAFE_0002);
      stray_en = 1'b1;
      do_txn(32'h1000_0080, 1'b0, 32'h0, 4'hF, 4, 1'b0, 32'h0F0F_1234);
      do_txn(32'h9000_0000, 1'b1, 32'h0000_0001, 4'h1, 0, 1'b0, 32'h0);
      do_txn(32'h0000_0000, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'h7777_0000);
      stray_en = 1'b0;

      // Reset in the middle of a forwarded access to a silent slave.
      drive_req(32'h2000_0010, 1'b0, 32'h0, 4'hF, 0, 1'b1, 32'h0, n);
      repeat (3) @(posedge wb_clk_i);
      #1;
      wb_rst_i = 1'b1;
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      m_cnt  = 16'h0;
      m_cnt2 = CNT2_INIT;
      @(posedge wb_clk_i);
      #1;
      check_all_zero("mid_fwd_reset");
      wb_rst_i = 1'b0;

      // Upstream abort: cyc drops while the slave is still silent.
      drive_req(32'h0000_0100, 1'b1, 32'h1111_2222, 4'hF, 0, 1'b1, 32'h0, n);
      repeat (2) @(posedge wb_clk_i);
      #1;
      chk(bus.wbm_stb_o == 4'b0001, "abort_pre_stb", 32'(bus.wbm_stb_o), 32'h1);
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      @(posedge wb_clk_i);
      #1;
      chk(bus.wbm_stb_o == 4'h0, "abort_stb", 32'(bus.wbm_stb_o), 32'h0);
      chk(bus.wbm_cyc_o == 4'h0, "abort_cyc", 32'(bus.wbm_cyc_o), 32'h0);
      chk(bus.wbs_ack_o == 1'b0, "abort_ack", 32'(bus.wbs_ack_o), 32'h0);
      repeat (3) @(posedge wb_clk_i);
      #1;
      chk(bus.err_cnt_o == m_cnt, "abort_err_cnt", 32'(bus.err_cnt_o), 32'(m_cnt));

      for (int t = 0; t < 150; t++) begin
         logic [31:0] a;
         a = {4'($urandom_range(0, 5)), 28'($urandom)};
         stray_en = ($urandom_range(0, 1) == 1);
         do_txn(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom),
                $urandom_range(0, 9), ($urandom_range(0, 7) == 0), $urandom);
      end
      stray_en = 1'b0;

      for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge wb_clk_i);
      #1;
      chk(exp_q.size() == 0, "queue_drained", 32'(exp_q.size()), 32'h0);
      chk(bus.err_cnt_o == m_cnt, "final_err_cnt", 32'(bus.err_cnt_o), 32'(m_cnt));
      chk(bus2.err_cnt_o == m_cnt2, "final_err_cnt_sat", 32'(bus2.err_cnt_o), 32'(m_cnt2));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
